alu_issue_stage: RTL and testbench

- Sequential wrapper around the 16-bit combinational ALU.
- Upstream side: accepts one operation per valid/ready handshake, registers operands A/B and applies the B-path shifter and the operand-select muxes, then drives Ain/Bin/ALUop into the ALU.
- Downstream side: captures the ALU result into the C register, computes status flags (Z, N, V) and presents them to writeback over a valid/ready handshake.

---
 rtl/alu_issue_stage_if.sv | 46 ++++
 rtl/alu_issue_stage.sv | 147 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Handshake and ALU-side bundle for alu_issue_stage: upstream operation fields,
// the combinational ALU connection and the writeback result port.
interface alu_issue_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_rdata_a;
  logic [DATA_W-1:0] in_rdata_b;
  logic [1:0]        in_aluop;
  logic [1:0]        in_shift;
  logic              in_asel;
  logic              in_bsel;
  logic [IMM_W-1:0]  in_imm;

  logic [1:0]        alu_op;
  logic [DATA_W-1:0] alu_ain;
  logic [DATA_W-1:0] alu_bin;
  logic [DATA_W-1:0] alu_result;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_c;
  logic [2:0]        out_status;

  // Stage side.
  modport slave (
    input  in_valid, in_rdata_a, in_rdata_b, in_aluop, in_shift, in_asel, in_bsel, in_imm,
    output in_ready,
    output alu_op, alu_ain, alu_bin,
    input  alu_result,
    output out_valid, out_c, out_status,
    input  out_ready
  );

  // Upstream, ALU and writeback side.
  modport master (
    output in_valid, in_rdata_a, in_rdata_b, in_aluop, in_shift, in_asel, in_bsel, in_imm,
    input  in_ready,
    input  alu_op, alu_ain, alu_bin,
    output alu_result,
    input  out_valid, out_c, out_status,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Sequential issue stage around the 16-bit combinational ALU: operand capture, B shifter,
// operand muxes, C register and {V,N,Z} status. ALU_ISSUE_STAGE_BYPASS_EN enables DONE->EXEC.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IMM_W  = 5
) (
  input logic             clk,
  input logic             reset,
  alu_issue_stage_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [IMM_W-1:0]  imm_q;
  logic [1:0]        op_q;
  logic [1:0]        shift_q;
  logic              asel_q;
  logic              bsel_q;
  logic [2:0]        status_q;

  logic              in_ready;
  logic              capture;
  logic [DATA_W-1:0] b_shift;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] ain;
  logic [DATA_W-1:0] bin;
  logic              flag_v;
  logic              flag_n;
  logic              flag_z;

`ifdef ALU_ISSUE_STAGE_BYPASS_EN
  // A result leaving DONE frees the stage in the same cycle.
  assign in_ready = in_ready_q | (out_valid_q & bus.out_ready);
`else
  assign in_ready = in_ready_q;
`endif

  assign capture = bus.in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (capture) begin
            state_q    <= StExec;
            in_ready_q <= 1'b0;
          end
        end
        StExec: begin
          state_q     <= StDone;
          out_valid_q <= 1'b1;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (capture) begin
              state_q <= StExec;
            end else begin
              state_q    <= StIdle;
              in_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      op_q     <= '0;
      shift_q  <= '0;
      asel_q   <= 1'b0;
      bsel_q   <= 1'b0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      if (capture) begin
        a_q     <= bus.in_rdata_a;
        b_q     <= bus.in_rdata_b;
        imm_q   <= bus.in_imm;
        op_q    <= bus.in_aluop;
        shift_q <= bus.in_shift;
        asel_q  <= bus.in_asel;
        bsel_q  <= bus.in_bsel;
      end
      if (state_q == StExec) begin
        c_q      <= bus.alu_result;
        status_q <= {flag_v, flag_n, flag_z};
      end
    end
  end

  always_comb begin
    b_shift = b_q;
    unique case (shift_q)
      2'b00: b_shift = b_q;
      2'b01: b_shift = {b_q[DATA_W-2:0], 1'b0};
      2'b10: b_shift = {1'b0, b_q[DATA_W-1:1]};
      2'b11: b_shift = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: b_shift = b_q;
    endcase
  end

  assign imm_ext = {{(DATA_W - IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign ain     = asel_q ? '0 : a_q;
  assign bin     = bsel_q ? imm_ext : b_shift;

  always_comb begin
    flag_z = (bus.alu_result == '0);
    flag_n = bus.alu_result[DATA_W-1];
    flag_v = 1'b0;
    case (op_q)
      2'b00: flag_v = (ain[DATA_W-1] == bin[DATA_W-1]) &&
                      (bus.alu_result[DATA_W-1] != ain[DATA_W-1]);
      2'b01: flag_v = (ain[DATA_W-1] != bin[DATA_W-1]) &&
                      (bus.alu_result[DATA_W-1] != ain[DATA_W-1]);
      default: flag_v = 1'b0;
    endcase
  end

  assign bus.in_ready   = in_ready;
  assign bus.alu_op     = op_q;
  assign bus.alu_ain    = ain;
  assign bus.alu_bin    = bin;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_c      = c_q;
  assign bus.out_status = status_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed plan cases, randomized operations with
// random writeback backpressure, reset mid-operation and a throughput check.
module tb_alu_issue_stage;

  logic clk;
  logic reset;

  alu_issue_stage_if #(.DATA_W(16), .IMM_W(5)) bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU behaviour.
  always_comb begin
    case (bus.alu_op)
      2'b00:   bus.alu_result = bus.alu_ain + bus.alu_bin;
      2'b01:   bus.alu_result = bus.alu_ain - bus.alu_bin;
      2'b10:   bus.alu_result = bus.alu_ain & bus.alu_bin;
      default: bus.alu_result = ~bus.alu_bin;
    endcase
  end

`ifdef ALU_ISSUE_STAGE_BYPASS_EN
  localparam int Period = 2;
`else
  localparam int Period = 3;
`endif

  typedef struct {
    int c;
    int st;
    int ain;
    int bin;
    int op;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   thr_mode = 1'b0;
  int   last_rise = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  // Reference computed from operand values with plain integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int op, input int sh,
                                 input int asel, input int bsel, input int imm);
    exp_t e;
    int sb, av, bv, r, s, v;
    case (sh)
      0:       sb = b;
      1:       sb = (b * 2) % 65536;
      2:       sb = b / 2;
      default: sb = b / 2 + ((b >= 32768) ? 32768 : 0);
    endcase
    bv = bsel ? ((imm >= 16) ? imm + 65536 - 32 : imm) : sb;
    av = asel ? 0 : a;
    v  = 0;
    case (op)
      0: begin
        r = (av + bv) % 65536;
        s = to_signed(av) + to_signed(bv);
        v = (s > 32767 || s < -32768) ? 1 : 0;
      end
      1: begin
        r = (av - bv + 65536) % 65536;
        s = to_signed(av) - to_signed(bv);
        v = (s > 32767 || s < -32768) ? 1 : 0;
      end
      2:       r = av & bv;
      default: r = 65535 - bv;
    endcase
    e.c   = r;
    e.st  = v * 4 + ((r >= 32768) ? 2 : 0) + ((r == 0) ? 1 : 0);
    e.ain = av;
    e.bin = bv;
    e.op  = op;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  logic        prev_valid;
  logic        prev_ready;
  logic [15:0] prev_c;
  logic [2:0]  prev_st;

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
      if (acc_q.size() > 0 && cyc == acc_q[0] && exp_q.size() > 0) begin
        chk("exec_alu_ain", 32'(bus.alu_ain), 32'(exp_q[0].ain));
        chk("exec_alu_bin", 32'(bus.alu_bin), 32'(exp_q[0].bin));
        chk("exec_alu_op", 32'(bus.alu_op), 32'(exp_q[0].op));
      end
      if (bus.out_valid && !prev_valid) begin
        if (acc_q.size() == 0) begin
          chk("spurious_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("latency", 32'(cyc), 32'(acc_q.pop_front() + 1));
        end
        if (thr_mode) begin
          if (last_rise >= 0) chk("throughput", 32'(cyc - last_rise), 32'(Period));
          last_rise = cyc;
        end
      end
      if (prev_valid && !prev_ready) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_c", 32'(bus.out_c), 32'(prev_c));
        chk("hold_status", 32'(bus.out_status), 32'(prev_st));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("result_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_c", 32'(bus.out_c), 32'(e.c));
          chk("out_status", 32'(bus.out_status), 32'(e.st));
        end
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_c     = bus.out_c;
      prev_st    = bus.out_status;
    end
  end

  task automatic send(input int a, input int b, input int op, input int sh, input int asel,
                      input int bsel, input int imm, input bit rnd_ready);
    int n;
    bus.in_rdata_a = 16'(a);
    bus.in_rdata_b = 16'(b);
    bus.in_aluop   = 2'(op);
    bus.in_shift   = 2'(sh);
    bus.in_asel    = 1'(asel);
    bus.in_bsel    = 1'(bsel);
    bus.in_imm     = 5'(imm);
    bus.in_valid   = 1'b1;
    if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
    exp_q.push_back(model(a, b, op, sh, asel, bsel, imm));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_rdata_a = '0;
    bus.in_rdata_b = '0;
    bus.in_aluop   = '0;
    bus.in_shift   = '0;
    bus.in_asel    = 1'b0;
    bus.in_bsel    = 1'b0;
    bus.in_imm     = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_c", 32'(bus.out_c), 32'd0);
    chk("rst_status", 32'(bus.out_status), 32'd0);
    chk("rst_alu_ain", 32'(bus.alu_ain), 32'd0);
    chk("rst_alu_bin", 32'(bus.alu_bin), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    send('h7FFF, 'h0001, 0, 0, 0, 0, 0, 1'b0);
    send('h0005, 'h0005, 1, 0, 0, 0, 0, 1'b0);
    send('hF0F0, 'h0FF0, 2, 0, 0, 0, 0, 1'b0);
    send('h0000, 'h8001, 3, 3, 0, 0, 0, 1'b0);
    send('h1234, 'h5555, 0, 0, 1, 1, 'b10000, 1'b0);
    send('h8000, 'h0001, 1, 1, 0, 0, 0, 1'b0);
    send('h4321, 'h8001, 0, 2, 0, 0, 0, 1'b0);
    drain();

    // Writeback stalls for five cycles; a stray in_valid pulse must be refused.
    bus.out_ready = 1'b0;
    send('h1111, 'h2222, 0, 0, 0, 0, 0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (i == 2);
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_back_idle", 32'(bus.in_ready), 32'd1);
    chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while the operation sits in EXEC.
    send('h0F0F, 'h0101, 0, 0, 0, 0, 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_c", 32'(bus.out_c), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_alu_ain", 32'(bus.alu_ain), 32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    send('h0003, 'h0004, 0, 1, 0, 0, 0, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), 1'b1);
    end
    drain();

    thr_mode  = 1'b1;
    last_rise = -1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), 0, 0, 0, 0, 0,
           1'b0);
    end
    drain();
    thr_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
